// File: rtl/ksk_mgr_common_param_pkg.sv
// Shared constants and types for the KSK manager node chain.
// Derived widths are computed here so that every block agrees on field sizes.
package ksk_mgr_common_param_pkg;

  localparam int KS_BLOCK_LINE_NB = 16;
  localparam int KS_LG_NB         = 3;
  localparam int KSK_SLOT_NB      = 8;
  localparam int CREDIT_NB        = 4;

  localparam int KSK_SLOT_DEPTH = KS_BLOCK_LINE_NB * KS_LG_NB;
  localparam int KSK_RAM_DEPTH  = KSK_SLOT_DEPTH * KSK_SLOT_NB;
  localparam int KSK_RAM_ADD_W  = $clog2(KSK_RAM_DEPTH);
  localparam int KSK_SLOT_W     = $clog2(KSK_SLOT_NB);
  localparam int LINE_NB_W      = $clog2(KS_BLOCK_LINE_NB + 1);
  localparam int LG_W           = (KS_LG_NB > 1) ? $clog2(KS_LG_NB) : 1;
  localparam int CREDIT_W       = $clog2(CREDIT_NB + 1);

  typedef struct packed {
    logic                     buf_shift;
    logic                     buf_in_avail;
    logic                     ram_rd_enD;
    logic [KSK_RAM_ADD_W-1:0] ram_rd_addD;
  } node_cmd_t;

  localparam int NODE_CMD_W = $bits(node_cmd_t);

  typedef struct packed {
    logic [KSK_SLOT_W-1:0] slot;
    logic [LINE_NB_W-1:0]  line_nb;
  } ksk_rd_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } rd_state_e;

  function automatic logic [LINE_NB_W-1:0] clamp_line_nb(input logic [LINE_NB_W-1:0] n);
    return (n > LINE_NB_W'(KS_BLOCK_LINE_NB)) ? LINE_NB_W'(KS_BLOCK_LINE_NB) : n;
  endfunction

  // Start address of a slot; evaluated once per command, not per read.
  function automatic logic [KSK_RAM_ADD_W-1:0] slot_base(input logic [KSK_SLOT_W-1:0] s);
    return KSK_RAM_ADD_W'(s) * KSK_RAM_ADD_W'(KSK_SLOT_DEPTH);
  endfunction

endpackage

// File: rtl/ksk_mgr_credit_cnt.sv
// Node-chain buffer credit counter: starts full, one credit per line started,
// one credit back per freed buffer line; saturates at CREDIT_NB.
module ksk_mgr_credit_cnt
  import ksk_mgr_common_param_pkg::*;
(
  input  logic clk,
  input  logic a_rst_n,
  input  logic inc,
  input  logic dec,
  output logic avail
);

  localparam logic [CREDIT_W-1:0] CREDIT_FULL = CREDIT_W'(CREDIT_NB);

  logic [CREDIT_W-1:0] credit_q;

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      credit_q <= CREDIT_FULL;
    end else if (inc && !dec && (credit_q != CREDIT_FULL)) begin
      credit_q <= credit_q + 1'b1;
    end else if (dec && !inc && (credit_q != '0)) begin
      credit_q <= credit_q - 1'b1;
    end
  end

  assign avail = (credit_q != '0);

  always_ff @(posedge clk) begin
    if (a_rst_n) begin
      assert (!(inc && !dec && (credit_q == CREDIT_FULL)))
        else $error("ksk_mgr_credit_cnt: credit returned while counter already full");
    end
  end

endmodule

// File: rtl/ksk_mgr_rd_cmd_gen.sv
// Read-command sequencer: turns one (slot, line_nb) command into a stream of
// per-lg RAM reads for the node chain, throttled by slot readiness and credits.
module ksk_mgr_rd_cmd_gen
  import ksk_mgr_common_param_pkg::*;
(
  input  logic                   clk,
  input  logic                   a_rst_n,
  input  logic                   cmd_vld,
  output logic                   cmd_rdy,
  input  logic [KSK_SLOT_W-1:0]  cmd_slot,
  input  logic [LINE_NB_W-1:0]   cmd_line_nb,
  input  logic [KSK_SLOT_NB-1:0] slot_loaded,
  input  logic                   credit_inc,
  output logic [NODE_CMD_W-1:0]  node_cmd,
  output logic                   node_cmd_vld,
  output logic                   slot_rd_done,
  output logic [KSK_SLOT_W-1:0]  slot_rd_done_id,
  output logic                   busy
);

  localparam logic [LG_W-1:0] LAST_LG = LG_W'(KS_LG_NB - 1);

  rd_state_e                state, state_nxt;
  ksk_rd_cmd_t              cmd_in;
  ksk_rd_cmd_t              rd_q;         // line_nb counts lines not yet started
  logic [LG_W-1:0]          lg_q;         // lg currently presented on node_cmd
  logic [KSK_RAM_ADD_W-1:0] addr_q;       // next address to issue
  logic [KSK_SLOT_NB-1:0]   slot_loaded_q;
  node_cmd_t                node_cmd_q;
  logic                     done_q;
  logic [KSK_SLOT_W-1:0]    done_id_q;

  logic                 credit_avail;
  logic                 slot_go;
  logic                 accept, line_start, ld, ld_done;
  logic [LG_W-1:0]      ld_lg;
  logic [LINE_NB_W-1:0] lines_after;

  // Handshake: a command transfers on cmd_vld && cmd_rdy (cmd_rdy only in IDLE);
  // node_cmd_vld and slot_rd_done are single-cycle qualifiers with no backpressure.

  ksk_mgr_credit_cnt u_credit (
    .clk     (clk),
    .a_rst_n (a_rst_n),
    .inc     (credit_inc),
    .dec     (line_start),
    .avail   (credit_avail)
  );

  assign slot_go = slot_loaded_q[rd_q.slot] && credit_avail;

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // The first read of a line is loaded on the decision cycle so the RUN state
  // is aligned with the reads actually presented on node_cmd.
  always_comb begin
    state_nxt      = state;
    accept         = 1'b0;
    line_start     = 1'b0;
    ld             = 1'b0;
    ld_lg          = '0;
    cmd_in.slot    = cmd_slot;
    cmd_in.line_nb = clamp_line_nb(cmd_line_nb);
    unique case (state)
      ST_IDLE: begin
        if (cmd_vld) begin
          accept = 1'b1;
          if (cmd_in.line_nb != '0) state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (slot_go) begin
          line_start = 1'b1;
          ld         = 1'b1;
          state_nxt  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (lg_q != LAST_LG) begin
          ld    = 1'b1;
          ld_lg = lg_q + 1'b1;
        end else if (rd_q.line_nb == '0) begin
          state_nxt = ST_IDLE;
        end else if (slot_go) begin
          line_start = 1'b1;
          ld         = 1'b1;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign lines_after = rd_q.line_nb - LINE_NB_W'(line_start);
  assign ld_done     = ld && (ld_lg == LAST_LG) && (lines_after == '0);

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      rd_q          <= '0;
      lg_q          <= '0;
      addr_q        <= '0;
      slot_loaded_q <= '0;
      node_cmd_q    <= '0;
      done_q        <= 1'b0;
      done_id_q     <= '0;
    end else begin
      slot_loaded_q <= slot_loaded;
      node_cmd_q    <= '0;
      done_q        <= 1'b0;
      done_id_q     <= '0;
      if (accept) begin
        rd_q   <= cmd_in;
        addr_q <= slot_base(cmd_in.slot);
        if (cmd_in.line_nb == '0) begin
          done_q    <= 1'b1;
          done_id_q <= cmd_in.slot;
        end
      end
      if (line_start) rd_q.line_nb <= lines_after;
      if (ld) begin
        node_cmd_q.ram_rd_enD   <= 1'b1;
        node_cmd_q.ram_rd_addD  <= addr_q;
        node_cmd_q.buf_in_avail <= (ld_lg == '0);
        node_cmd_q.buf_shift    <= (ld_lg == LAST_LG);
        addr_q                  <= addr_q + 1'b1;
        lg_q                    <= ld_lg;
        if (ld_done) begin
          done_q    <= 1'b1;
          done_id_q <= rd_q.slot;
        end
      end
    end
  end

  assign cmd_rdy         = (state == ST_IDLE);
  assign busy            = (state != ST_IDLE);
  assign node_cmd        = node_cmd_q;
  assign node_cmd_vld    = node_cmd_q.ram_rd_enD;
  assign slot_rd_done    = done_q;
  assign slot_rd_done_id = done_id_q;

  always_ff @(posedge clk) begin
    if (a_rst_n && (state == ST_RUN)) begin
      assert (slot_loaded_q[rd_q.slot])
        else $error("ksk_mgr_rd_cmd_gen: active slot unloaded while reading");
    end
  end

endmodule

// File: tb/tb_ksk_mgr_rd_cmd_gen.sv
// Bench for ksk_mgr_rd_cmd_gen: directed timing scenarios plus random commands,
// with a queue scoreboard fed from a line/lg address model.
module tb_ksk_mgr_rd_cmd_gen;
  import ksk_mgr_common_param_pkg::*;

  localparam int SB_W = NODE_CMD_W + 1 + KSK_SLOT_W;

  logic                   clk;
  logic                   a_rst_n;
  logic                   cmd_vld;
  logic                   cmd_rdy;
  logic [KSK_SLOT_W-1:0]  cmd_slot;
  logic [LINE_NB_W-1:0]   cmd_line_nb;
  logic [KSK_SLOT_NB-1:0] slot_loaded;
  logic                   credit_inc;
  logic [NODE_CMD_W-1:0]  node_cmd;
  logic                   node_cmd_vld;
  logic                   slot_rd_done;
  logic [KSK_SLOT_W-1:0]  slot_rd_done_id;
  logic                   busy;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int lines_seen = 0;
  int incs_total = 0;
  int max_addr = 0;
  bit auto_credit = 1'b0;

  logic [SB_W-1:0] exp_q[$];
  int vld_cyc_q[$];
  int done_cyc_q[$];

  node_cmd_t mon_nc;
  assign mon_nc = node_cmd_t'(node_cmd);

  ksk_mgr_rd_cmd_gen dut (
    .clk             (clk),
    .a_rst_n         (a_rst_n),
    .cmd_vld         (cmd_vld),
    .cmd_rdy         (cmd_rdy),
    .cmd_slot        (cmd_slot),
    .cmd_line_nb     (cmd_line_nb),
    .slot_loaded     (slot_loaded),
    .credit_inc      (credit_inc),
    .node_cmd        (node_cmd),
    .node_cmd_vld    (node_cmd_vld),
    .slot_rd_done    (slot_rd_done),
    .slot_rd_done_id (slot_rd_done_id),
    .busy            (busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Expected read stream of one command, from the slot/line/lg address rule.
  task automatic push_model(input int slot, input int n);
    int n_eff;
    node_cmd_t nc;
    n_eff = (n > KS_BLOCK_LINE_NB) ? KS_BLOCK_LINE_NB : n;
    if (n_eff == 0) begin
      exp_q.push_back({NODE_CMD_W'(0), 1'b1, KSK_SLOT_W'(slot)});
      return;
    end
    for (int line = 0; line < n_eff; line++) begin
      for (int lg = 0; lg < KS_LG_NB; lg++) begin
        bit last;
        last = (line == n_eff - 1) && (lg == KS_LG_NB - 1);
        nc.ram_rd_enD   = 1'b1;
        nc.ram_rd_addD  = KSK_RAM_ADD_W'(slot * KSK_SLOT_DEPTH + line * KS_LG_NB + lg);
        nc.buf_in_avail = (lg == 0);
        nc.buf_shift    = (lg == KS_LG_NB - 1);
        exp_q.push_back({nc, last, last ? KSK_SLOT_W'(slot) : KSK_SLOT_W'(0)});
      end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (a_rst_n) begin
      if (node_cmd_vld || slot_rd_done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_unexpected: got=0x%0h expected=none (cycle %0d)",
                   {node_cmd, slot_rd_done, slot_rd_done_id}, cyc);
        end else begin
          check("sb_output", 32'({node_cmd, slot_rd_done, slot_rd_done_id}), 32'(exp_q.pop_front()));
        end
      end else begin
        check("idle_node_cmd_zero", 32'(node_cmd), 32'd0);
      end
      if (node_cmd_vld) begin
        vld_cyc_q.push_back(cyc);
        if (mon_nc.buf_in_avail) lines_seen++;
        if (int'(mon_nc.ram_rd_addD) > max_addr) max_addr = int'(mon_nc.ram_rd_addD);
      end
      if (slot_rd_done) done_cyc_q.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  // Advance one cycle; inputs change 1 time unit after the rising edge.
  // Credits are only ever returned for lines already seen, so the DUT never overflows.
  task automatic step(input bit force_inc);
    @(posedge clk);
    #1;
    credit_inc = 1'b0;
    if (force_inc || (auto_credit && (incs_total < lines_seen) && ($urandom_range(0, 1) == 1))) begin
      credit_inc = 1'b1;
      incs_total++;
    end
  endtask

  task automatic issue_cmd(input int slot, input int n, output int t_cmd);
    int guard;
    push_model(slot, n);
    cmd_vld     = 1'b1;
    cmd_slot    = KSK_SLOT_W'(slot);
    cmd_line_nb = LINE_NB_W'(n);
    guard = 0;
    while (!cmd_rdy && guard < 3000) begin
      step(1'b0);
      guard++;
    end
    if (!cmd_rdy) begin
      n_cmp++;
      n_fail++;
      $display("FAIL cmd_accept_timeout: got=cmd_rdy 0 expected=cmd_rdy 1 (cycle %0d)", cyc);
    end
    t_cmd = cyc;
    step(1'b0);
    cmd_vld = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while ((busy || exp_q.size() != 0) && guard < 3000) begin
      step(1'b0);
      guard++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic restore_credit();
    int guard;
    guard = 0;
    while (incs_total < lines_seen && guard < 100) begin
      step(1'b1);
      guard++;
    end
    step(1'b0);
  endtask

  task automatic settle(input string name);
    auto_credit = 1'b1;
    wait_idle(name);
    restore_credit();
    auto_credit = 1'b0;
  endtask

  function automatic int first_cyc();
    return (vld_cyc_q.size() > 0) ? vld_cyc_q[0] : -1;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int t, t2, c, d, s, n_done;
    a_rst_n     = 1'b0;
    cmd_vld     = 1'b0;
    cmd_slot    = '0;
    cmd_line_nb = '0;
    slot_loaded = 8'h04;
    credit_inc  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_node_cmd_vld", 32'(node_cmd_vld), 32'd0);
    check("rst_node_cmd", 32'(node_cmd), 32'd0);
    check("rst_slot_rd_done", 32'(slot_rd_done), 32'd0);
    check("rst_slot_rd_done_id", 32'(slot_rd_done_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
    @(posedge clk);
    #1 a_rst_n = 1'b1;
    step(1'b0);
    step(1'b0);

    // Basic: slot 2, two lines, reads on consecutive cycles from T+2.
    vld_cyc_q.delete();
    done_cyc_q.delete();
    issue_cmd(2, 2, t);
    repeat (12) step(1'b0);
    check("basic_read_count", 32'(vld_cyc_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < vld_cyc_q.size()) check("basic_read_cycle", 32'(vld_cyc_q[i]), 32'(t + 2 + i));
    end
    check("basic_done_count", 32'(done_cyc_q.size()), 32'd1);
    if (done_cyc_q.size() > 0) check("basic_done_cycle", 32'(done_cyc_q[0]), 32'(t + 7));
    settle("basic_drain");

    // Credits: six lines with no returns stop after four lines.
    slot_loaded = 8'h02;
    vld_cyc_q.delete();
    issue_cmd(1, 6, t);
    repeat (30) step(1'b0);
    check("credit_stall_reads", 32'(vld_cyc_q.size()), 32'd12);
    check("credit_stall_busy", 32'(busy), 32'd1);
    vld_cyc_q.delete();
    step(1'b1);
    c = cyc;
    repeat (6) step(1'b0);
    check("credit_resume_cycle", 32'(first_cyc()), 32'(c + 2));
    check("credit_resume_reads", 32'(vld_cyc_q.size()), 32'd3);
    vld_cyc_q.delete();
    step(1'b1);
    d = cyc;
    step(1'b1);
    repeat (6) step(1'b0);
    check("credit_last_line_cycle", 32'(first_cyc()), 32'(d + 2));
    check("credit_last_line_reads", 32'(vld_cyc_q.size()), 32'd3);
    vld_cyc_q.delete();
    issue_cmd(1, 2, t);
    repeat (15) step(1'b0);
    check("credit_simul_kept_one", 32'(vld_cyc_q.size()), 32'd3);
    check("credit_simul_busy", 32'(busy), 32'd1);
    settle("credit_drain");

    // Slot not loaded: waits, then starts two cycles after the bit rises.
    slot_loaded = 8'h00;
    vld_cyc_q.delete();
    issue_cmd(5, 1, t);
    repeat (10) step(1'b0);
    check("unloaded_no_reads", 32'(vld_cyc_q.size()), 32'd0);
    check("unloaded_busy", 32'(busy), 32'd1);
    slot_loaded = 8'h20;
    s = cyc;
    repeat (6) step(1'b0);
    check("loaded_first_read_cycle", 32'(first_cyc()), 32'(s + 2));
    settle("unloaded_drain");

    // Zero lines: done one cycle after acceptance, no reads.
    vld_cyc_q.delete();
    done_cyc_q.delete();
    issue_cmd(7, 0, t);
    check("zero_cmd_rdy_t1", 32'(cmd_rdy), 32'd1);
    repeat (4) step(1'b0);
    check("zero_no_reads", 32'(vld_cyc_q.size()), 32'd0);
    check("zero_done_count", 32'(done_cyc_q.size()), 32'd1);
    if (done_cyc_q.size() > 0) check("zero_done_cycle", 32'(done_cyc_q[0]), 32'(t + 1));
    settle("zero_drain");

    // Clamp to 16 lines on the last slot, then a back-to-back command.
    slot_loaded = 8'h81;
    auto_credit = 1'b1;
    vld_cyc_q.delete();
    done_cyc_q.delete();
    max_addr = 0;
    issue_cmd(7, 20, t);
    issue_cmd(0, 1, t2);
    settle("clamp_drain");
    check("clamp_read_count", 32'(vld_cyc_q.size()), 32'd51);
    check("clamp_max_addr", 32'(max_addr), 32'(KSK_RAM_DEPTH - 1));
    if (done_cyc_q.size() > 0) check("b2b_accept_cycle", 32'(t2), 32'(done_cyc_q[0] + 1));
    else check("b2b_done_seen", 32'(done_cyc_q.size()), 32'd1);

    // Random commands against the model.
    slot_loaded = 8'hFF;
    auto_credit = 1'b1;
    for (int k = 0; k < 14; k++) begin
      int rs, rn;
      rs = int'($urandom_range(0, KSK_SLOT_NB - 1));
      case ($urandom_range(0, 5))
        0:       rn = 0;
        1:       rn = int'($urandom_range(17, 31));
        default: rn = int'($urandom_range(1, 16));
      endcase
      issue_cmd(rs, rn, t);
      repeat ($urandom_range(0, 3)) step(1'b0);
    end
    settle("random_drain");

    // Asynchronous reset in the middle of a command.
    slot_loaded = 8'h08;
    vld_cyc_q.delete();
    issue_cmd(3, 4, t);
    for (int g = 0; g < 50 && vld_cyc_q.size() < 2; g++) step(1'b0);
    check("rst_mid_reads_started", 32'(vld_cyc_q.size() >= 2), 32'd1);
    n_done = done_cyc_q.size();
    #1;
    a_rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_vld_zero", 32'(node_cmd_vld), 32'd0);
    check("rst_mid_node_cmd_zero", 32'(node_cmd), 32'd0);
    check("rst_mid_busy_zero", 32'(busy), 32'd0);
    check("rst_mid_done_zero", 32'(slot_rd_done), 32'd0);
    step(1'b0);
    step(1'b0);
    a_rst_n = 1'b1;
    incs_total = lines_seen;
    step(1'b0);
    check("rst_mid_cmd_rdy", 32'(cmd_rdy), 32'd1);
    check("rst_mid_no_done", 32'(done_cyc_q.size()), 32'(n_done));
    vld_cyc_q.delete();
    issue_cmd(3, 6, t);
    repeat (30) step(1'b0);
    check("rst_mid_credit_full", 32'(vld_cyc_q.size()), 32'd12);
    settle("rst_mid_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
